// File: rtl/uart_tx8.sv
// rtl/uart_tx8.sv - 8N1 UART transmitter with a 4-entry byte FIFO.
// Async active-low reset; txd is registered so the line never glitches.
module uart_tx8 #(
  parameter int CLKS     = 100000000,
  parameter int BAUDRATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       wr,
  output logic       full,
  output logic       overflow,
  output logic       busy,
  output logic       tx_done,
  output logic       txd
);

  localparam int DIV = CLKS / BAUDRATE;
  localparam int TW  = $clog2(DIV);
  localparam logic [TW-1:0] TLAST = TW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          ovf_q;
  logic [7:0]    mem_q [4];
  logic [1:0]    wptr_q, rptr_q;
  logic [2:0]    count_q;

  logic fifo_empty, push, pop, bit_end;

  assign fifo_empty = (count_q == 3'd0);
  assign full       = (count_q == 3'd4);
  assign push       = wr && !full;
  assign bit_end    = (timer_q == TLAST);

  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE) || !fifo_empty;
  assign tx_done  = (state_q == STOP) && bit_end;
  assign txd      = txd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!fifo_empty) state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && (idx_q == 3'd7)) state_d = STOP;
      STOP:  if (bit_end) state_d = fifo_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Popping at the end of STOP chains frames without an idle gap.
  always_comb begin
    pop = ((state_q == IDLE) && !fifo_empty) ||
          ((state_q == STOP) && bit_end && !fifo_empty);
    timer_d = (pop || bit_end || (state_q == IDLE)) ? '0 : timer_q + TW'(1);
    idx_d = idx_q;
    if ((state_q == START) && bit_end) idx_d = 3'd0;
    else if ((state_q == DATA) && bit_end) idx_d = idx_q + 3'd1;
    shift_d = pop ? mem_q[rptr_q] : shift_q;
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[idx_d];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
      wptr_q  <= 2'd0;
      rptr_q  <= 2'd0;
      count_q <= 3'd0;
    end else begin
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      ovf_q   <= wr && full;
      if (push) wptr_q <= wptr_q + 2'd1;
      if (pop) rptr_q <= rptr_q + 2'd1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= din;
  end

endmodule

// File: tb/tb_uart_tx8.sv
// tb/tb_uart_tx8.sv - directed self-checking bench for uart_tx8 (DIV=16).
module tb_uart_tx8;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] din = 8'd0;
  logic       full, overflow, busy, tx_done, txd;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ovf_cnt = 0;

  uart_tx8 #(.CLKS(16), .BAUDRATE(1)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .wr(wr), .full(full),
    .overflow(overflow), .busy(busy), .tx_done(tx_done), .txd(txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (overflow === 1'b1) ovf_cnt <= ovf_cnt + 1;

  task automatic wr_byte(input logic [7:0] b, output int k);
    @(negedge clk);
    din = b;
    wr = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    wr = 1'b0;
  endtask

  // Waits for a start bit, then samples each bit mid-period.
  task automatic recv_frame(output logic [7:0] data, output int st, output int done,
                            output logic ok, output logic framed);
    logic [9:0] bits;
    logic found;
    bits = '0;
    found = 1'b0;
    data = 8'd0;
    st = -1;
    done = -1;
    ok = 1'b0;
    framed = 1'b0;
    for (int n = 0; n < 400 && !found; n++) begin
      @(negedge clk);
      if (txd === 1'b0) found = 1'b1;
    end
    if (found) begin
      st = cyc;
      ok = 1'b1;
      for (int i = 0; i < 160; i++) begin
        if (i > 0) @(negedge clk);
        if (i % 16 == 8) bits[i/16] = txd;
        if (tx_done === 1'b1 && done < 0) done = cyc;
      end
      data = bits[8:1];
      framed = (bits[0] == 1'b0) && (bits[9] == 1'b1);
    end
  endtask

  task automatic test_reset;
    int toggles;
    logic prev;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b exp=1", txd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", tx_done); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    rst_n = 1'b1;
    toggles = 0;
    prev = txd;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txd !== prev) toggles++;
      prev = txd;
    end
    total++; if (toggles != 0) begin bad++; $display("FAIL idle_toggles got=%0d exp=0", toggles); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single;
    int k, st, done;
    logic [7:0] d;
    logic ok, fr;
    wr_byte(8'h55, k);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    recv_frame(d, st, done, ok, fr);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL single_timeout got=%b exp=1", ok); end
    total++; if (st != k + 1) begin bad++; $display("FAIL single_start got=%0d exp=%0d", st, k + 1); end
    total++; if (d !== 8'h55) begin bad++; $display("FAIL single_data got=%h exp=55", d); end
    total++; if (fr !== 1'b1) begin bad++; $display("FAIL single_framing got=%b exp=1", fr); end
    total++; if (done != k + 160) begin bad++; $display("FAIL single_done got=%0d exp=%0d", done, k + 160); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL single_txd_end got=%b exp=1", txd); end
  endtask

  task automatic test_back_to_back;
    int k1, k2, st1, st2, dn1, dn2;
    logic [7:0] d1, d2;
    logic ok1, ok2, fr1, fr2;
    wr_byte(8'hA3, k1);
    wr_byte(8'h0F, k2);
    recv_frame(d1, st1, dn1, ok1, fr1);
    recv_frame(d2, st2, dn2, ok2, fr2);
    total++; if (st1 != k1 + 1) begin bad++; $display("FAIL b2b_start1 got=%0d exp=%0d", st1, k1 + 1); end
    total++; if (d1 !== 8'hA3 || fr1 !== 1'b1) begin bad++; $display("FAIL b2b_data1 got=%h exp=a3", d1); end
    total++; if (d2 !== 8'h0F || fr2 !== 1'b1) begin bad++; $display("FAIL b2b_data2 got=%h exp=0f", d2); end
    total++; if (st2 != dn1 + 1) begin bad++; $display("FAIL b2b_gap got=%0d exp=%0d", st2, dn1 + 1); end
    total++; if (dn2 - dn1 != 160) begin bad++; $display("FAIL b2b_done_spacing got=%0d exp=160", dn2 - dn1); end
  endtask

  task automatic test_overflow;
    logic [7:0] vals [6];
    logic [7:0] rx [5];
    logic       rok [5];
    int ovf0, lows;
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    ovf0 = ovf_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          int k;
          wr_byte(vals[i], k);
          if (i == 3) begin
            total++; if (full !== 1'b0) begin bad++; $display("FAIL ovf_full_early got=%b exp=0", full); end
          end
          if (i == 4) begin
            total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b exp=1", full); end
            total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", overflow); end
          end
          if (i == 5) begin
            total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b exp=1", overflow); end
          end
        end
      end
      begin
        for (int j = 0; j < 5; j++) begin
          int st, dn;
          logic fr;
          recv_frame(rx[j], st, dn, rok[j], fr);
        end
      end
    join
    for (int j = 0; j < 5; j++) begin
      total++;
      if (rok[j] !== 1'b1 || rx[j] !== vals[j]) begin
        bad++; $display("FAIL ovf_frame%0d got=%h exp=%h", j, rx[j], vals[j]);
      end
    end
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    total++; if (lows != 0) begin bad++; $display("FAIL ovf_sixth_frame got=%0d exp=0", lows); end
    total++; if (ovf_cnt - ovf0 != 1) begin bad++; $display("FAIL ovf_count got=%0d exp=1", ovf_cnt - ovf0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovf_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_reset_midframe;
    int k1, k2, lows, dones;
    wr_byte(8'hFF, k1);
    wr_byte(8'h12, k2);
    for (int n = 0; n < 100 && cyc < k1 + 50; n++) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL rstmid_txd got=%b exp=1", txd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL rstmid_full got=%b exp=0", full); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    dones = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
      if (tx_done !== 1'b0) dones++;
    end
    total++; if (lows != 0) begin bad++; $display("FAIL rstmid_frame got=%0d exp=0", lows); end
    total++; if (dones != 0) begin bad++; $display("FAIL rstmid_done got=%0d exp=0", dones); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_wrap;
    logic [7:0] vals [10];
    logic [7:0] rx [10];
    logic       rok [10];
    int ovf0;
    vals = '{8'h01, 8'h80, 8'hC3, 8'h3C, 8'h5A, 8'hA5, 8'hF0, 8'h0E, 8'h99, 8'h66};
    ovf0 = ovf_cnt;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          int k;
          wr_byte(vals[i], k);
          repeat (119) @(negedge clk);
        end
      end
      begin
        for (int j = 0; j < 10; j++) begin
          int st, dn;
          logic fr;
          recv_frame(rx[j], st, dn, rok[j], fr);
        end
      end
    join
    for (int j = 0; j < 10; j++) begin
      total++;
      if (rok[j] !== 1'b1 || rx[j] !== vals[j]) begin
        bad++; $display("FAIL wrap_frame%0d got=%h exp=%h", j, rx[j], vals[j]);
      end
    end
    total++; if (ovf_cnt != ovf0) begin bad++; $display("FAIL wrap_overflow got=%0d exp=0", ovf_cnt - ovf0); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
    test_reset_midframe;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
